duokeyin: RTL

Avalon-MM slave input peripheral, the input-side counterpart of the two-digit seven-segment output slaves in the media-center Qsys system. Samples up to 16 active-low push-button/switch pins, synchronises and debounces them, and captures press/release edges. Software reads state and edge flags and gets an interrupt. One instance per button bank, on the same clock as the display slaves.

---
 rtl/duokeyin.sv | 100 ++++++++++
 1 files changed

// File: rtl/duokeyin.sv
// Avalon-MM key input slave: synchronises, debounces and edge-captures active-low pins.
// Read latency 1, no wait states (never backpressures); irq is a registered |(EDGE & MASK).
module duokeyin #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             csi_clk,
  input  logic             csi_reset_n,
  input  logic [1:0]       avs_s1_address,
  input  logic             avs_s1_read,
  input  logic             avs_s1_write,
  input  logic [15:0]      avs_s1_writedata,
  input  logic [1:0]       avs_s1_byteenable,
  output logic [15:0]      avs_s1_readdata,
  input  logic [WIDTH-1:0] coe_keys,
  output logic             ins_irq
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_EDGE   = 2'd1;
  localparam logic [1:0] REG_MASK   = 2'd2;
  localparam logic [1:0] REG_CONFIG = 2'd3;

  logic [WIDTH-1:0] sync1, sync2;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] stable, stable_nxt;
  logic [CW-1:0]    cnt_q   [WIDTH];
  logic [CW-1:0]    cnt_nxt [WIDTH];
  logic [WIDTH-1:0] edge_q, mask_q;
  logic [1:0]       cfg_q;
  logic [WIDTH-1:0] edge_set, edge_clr;
  logic [15:0]      be_bits;
  logic [WIDTH-1:0] be_w, wr_bits;
  logic [15:0]      rd_mux;
  logic             wr_edge, wr_mask, wr_cfg;

  // Per-bit debounce: any sample matching the stable level restarts the count.
  always_comb begin
    level = ~sync2;
    stable_nxt = stable;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (level[i] != stable[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_nxt[i] = level[i];
        end else begin
          cnt_nxt[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    be_bits  = {{8{avs_s1_byteenable[1]}}, {8{avs_s1_byteenable[0]}}};
    be_w     = WIDTH'(be_bits);
    wr_bits  = WIDTH'(avs_s1_writedata & be_bits);
    wr_edge  = avs_s1_write && (avs_s1_address == REG_EDGE);
    wr_mask  = avs_s1_write && (avs_s1_address == REG_MASK);
    wr_cfg   = avs_s1_write && (avs_s1_address == REG_CONFIG) && avs_s1_byteenable[0];
    edge_set = (cfg_q[0] ? (stable_nxt & ~stable) : '0)
             | (cfg_q[1] ? (~stable_nxt & stable) : '0);
    edge_clr = wr_edge ? wr_bits : '0;
    rd_mux   = 16'h0000;
    case (avs_s1_address)
      REG_DATA: rd_mux = 16'(stable);
      REG_EDGE: rd_mux = 16'(edge_q);
      REG_MASK: rd_mux = 16'(mask_q);
      default:  rd_mux = {14'b0, cfg_q};
    endcase
  end

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      sync1           <= '1;
      sync2           <= '1;
      stable          <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      edge_q          <= '0;
      mask_q          <= '0;
      cfg_q           <= 2'b01;
      avs_s1_readdata <= 16'h0000;
      ins_irq         <= 1'b0;
    end else begin
      sync1  <= coe_keys;
      sync2  <= sync1;
      stable <= stable_nxt;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_nxt[i];
      // A capture in the same cycle as a W1C clear survives.
      edge_q <= (edge_q & ~edge_clr) | edge_set;
      if (wr_mask) mask_q <= (mask_q & ~be_w) | wr_bits;
      if (wr_cfg) cfg_q <= avs_s1_writedata[1:0];
      ins_irq <= |(edge_q & mask_q);
      if (avs_s1_read) avs_s1_readdata <= rd_mux;
    end
  end

endmodule
